// File: rtl/keypad_scan.sv
// keypad_scan
// Column-by-column scanner for a 4-row x 5-column active-low matrix keypad.
// Drives one column low at a time, samples the synchronised rows at the end of
// each column slot, folds a whole frame into the lowest pressed key index and
// debounces presses and releases over whole frames. Only one key is reported
// per press; further keys are ignored until every key has been released.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key
// stays held (REPEAT_DELAY frames to the first repeat, then every REPEAT_RATE
// frames). Without the macro no repeat logic exists and REPEAT_* are unused.
//
// Handshake: o_key_valid is a single-cycle strobe with no back-pressure; the
// consumer must capture o_key_value on any cycle where o_key_valid is high.
// o_key_value holds its last value between strobes.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [3:0] i_row,
    output logic [4:0] o_col,
    output logic [4:0] o_key_value,
    output logic       o_key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);

    // Elaboration-time guard against parameter values the scan cannot support
    // (the divider must leave room for the two-flop row synchroniser).
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_param_check
        $error("keypad_scan: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAND = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // Row synchroniser
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;

    // Column scan
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       col_q, col_d;
    logic             tick;
    logic             frame_end;

    // Frame accumulation
    logic [4:0]       col_code;
    logic [4:0]       sample_min;
    logic [4:0]       frame_min_q, frame_min_d;
    logic [4:0]       frame_code_q, frame_code_d;
    logic             frame_done_q, frame_done_d;

    // Debounce FSM (state_q is the observable state for checkers)
    state_t           state_q, state_d;
    logic [4:0]       cand_q, cand_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [DB_W-1:0]  rel_q, rel_d;
    logic [DB_W-1:0]  match_inc;
    logic [DB_W-1:0]  rel_inc;

    // Outputs
    logic             accept;
    logic             rpt_fire;
    logic [4:0]       key_value_q, key_value_d;
    logic             key_valid_q, key_valid_d;

    // Two-flop synchroniser; idles high to match the released (pulled-up) rows.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= i_row;
            row_sync_q <= row_meta_q;
        end
    end

    // The last cycle of a column slot is both the sample point and the
    // column advance; the slot of column 4 also closes the frame.
    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (col_q == 3'd4);

    // Scan divider and column counter next state.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        col_d = col_q;
        if (tick) begin
            div_d = '0;
            col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
        end
    end

    // Scan divider and column counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_q <= '0;
            col_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
        end
    end

    assign o_col = ~(5'd1 << col_q);

    // Key index of the lowest pressed row in the current column (0 = none).
    always_comb begin
        col_code = 5'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                col_code = 5'(r * 5) + {2'b00, col_q} + 5'd1;
            end
        end
    end

    // Running minimum over the frame; at frame end it becomes the frame code
    // and the accumulator restarts empty for the next frame.
    always_comb begin
        sample_min = frame_min_q;
        if (col_code != 5'd0 && (frame_min_q == 5'd0 || col_code < frame_min_q)) begin
            sample_min = col_code;
        end
        frame_min_d  = frame_min_q;
        frame_code_d = frame_code_q;
        frame_done_d = frame_end;
        if (tick) begin
            frame_min_d = frame_end ? 5'd0 : sample_min;
        end
        if (frame_end) begin
            frame_code_d = sample_min;
        end
    end

    // Frame accumulator and the registered frame code handed to the FSM.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            frame_min_q  <= '0;
            frame_code_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_min_q  <= frame_min_d;
            frame_code_q <= frame_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FSM state register with its candidate and debounce counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    // FSM next state, evaluated once per frame on the frame_done strobe.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        match_inc = cnt_q + DB_W'(1);
        rel_inc   = rel_q + DB_W'(1);
        if (frame_done_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_code_q != 5'd0) begin
                        cand_d = frame_code_q;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = ST_HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                        end else begin
                            state_d = ST_CAND;
                            cnt_d   = DB_W'(1);
                        end
                    end
                end
                ST_CAND: begin
                    if (frame_code_q == 5'd0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (frame_code_q != cand_q) begin
                        // A different key won this frame: debounce it afresh.
                        cand_d = frame_code_q;
                        cnt_d  = DB_W'(1);
                    end else if (match_inc == DB_MAX) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        rel_d   = '0;
                    end else begin
                        cnt_d = match_inc;
                    end
                end
                ST_HELD: begin
                    // Any key at all keeps the press alive; this is what
                    // suppresses rollover keys until a full release.
                    if (frame_code_q != 5'd0) begin
                        rel_d = '0;
                    end else if (rel_inc == DB_MAX) begin
                        state_d = ST_IDLE;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end
    end

    // FSM outputs: a press is accepted on the transition into HELD.
    always_comb begin
        accept      = frame_done_q && (state_q != ST_HELD) && (state_d == ST_HELD);
        key_value_d = accept ? cand_d : key_value_q;
        key_valid_d = accept || rpt_fire;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_inc;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_armed_q, rpt_armed_d;

    // Repeat timer: counts held frames, first to REPEAT_DELAY, then to
    // REPEAT_RATE; any frame outside HELD or with no key restarts it.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        rpt_inc     = rpt_cnt_q + RPT_W'(1);
        rpt_target  = rpt_armed_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
        if (frame_done_q) begin
            if (state_q != ST_HELD || frame_code_q == 5'd0) begin
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b0;
            end else if (rpt_inc == rpt_target) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_inc;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Registered key outputs; value and strobe change on the same edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            key_value_q <= '0;
            key_valid_q <= 1'b0;
        end else begin
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign o_key_value = key_value_q;
    assign o_key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3 (20-cycle
// frame). A behavioural keypad pulls row r low while key (r,c) is pressed and
// column c is driven low. Every pulse is logged with its value and the index
// of the clock edge that produced it. Define KEYPAD_REPEAT_EN for both the
// design and this file to exercise auto-repeat (REPEAT_DELAY=5, REPEAT_RATE=2).
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int RD       = 5;
    localparam int RR       = 2;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [3:0]  i_row;
    logic [4:0]  o_col;
    logic [4:0]  o_key_value;
    logic        o_key_valid;

    logic [19:0] pressed = '0;   // bit k-1 set = key k held
    int          cyc     = 0;    // posedges seen so far
    int          checks  = 0;
    int          passed  = 0;
    int          fails   = 0;
    logic [4:0]  pv_q[$];        // value of each pulse
    int          pc_q[$];        // edge index of each pulse
    logic [4:0]  col_seq [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

    keypad_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_row      (i_row),
        .o_col      (o_col),
        .o_key_value(o_key_value),
        .o_key_valid(o_key_valid)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Keypad matrix model
    always_comb begin
        i_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (pressed[r*5+c] && !o_col[c]) i_row[r] = 1'b0;
            end
        end
    end

    // Pulse logger, sampled 1 time unit after each active edge
    always @(posedge i_clk) begin
        #1;
        cyc = cyc + 1;
        if (o_key_valid === 1'b1) begin
            pv_q.push_back(o_key_value);
            pc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_col(input logic [4:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge i_clk);
            if (o_col === target) ok = 1'b1;
        end
    endtask

    // Returns at the first negedge after a column 4 -> 0 wrap; f is the
    // index of the edge that started the new frame.
    task automatic wait_frame_start(output bit ok, output int f);
        logic [4:0] prev;
        ok   = 1'b0;
        f    = 0;
        prev = o_col;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge i_clk);
            if (prev === 5'b01111 && o_col === 5'b11110) begin
                ok = 1'b1;
                f  = cyc;
            end
            prev = o_col;
        end
    endtask

    function automatic int pulse_delta(input int idx, input int base);
        return (pc_q.size() > idx) ? pc_q[idx] - base : -1;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit ok;
        int f;
        int n0;

        // Reset values and column stepping
        i_rstn = 1'b0;
        #1;
        check("rst_col", o_col, 5'b11110);
        check("rst_value", o_key_value, 5'd0);
        check("rst_valid", o_key_valid, 1'b0);
        hold(2);
        i_rstn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (k == 3 || k % 4 == 0)
                check($sformatf("col_step_k%0d", k), o_col, col_seq[(k/4)%5]);
        end
        check("idle_no_pulse", pc_q.size(), 0);

        // Single press of key 8 (row 1, col 2), applied during column 4
        wait_col(5'b01111, ok);
        check("sp_sync_col", ok, 1'b1);
        pressed[7] = 1'b1;
        wait_frame_start(ok, f);
        check("sp_sync_frame", ok, 1'b1);
        n0 = pc_q.size();
        hold(200);
        check("sp_count", pc_q.size() - n0, 1);
        check("sp_value", o_key_value, 5'd8);
        check("sp_latency", pulse_delta(n0, f), 61);
        pressed = '0;
        hold(120);
        check("sp_release_count", pc_q.size() - n0, 1);
        check("sp_release_value", o_key_value, 5'd8);

        // Press of key 2 lasting only two frames is not accepted
        wait_frame_start(ok, f);
        check("short_sync", ok, 1'b1);
        n0 = pc_q.size();
        pressed[1] = 1'b1;
        hold(40);
        pressed[1] = 1'b0;
        hold(100);
        check("short_count", pc_q.size() - n0, 0);
        check("short_value", o_key_value, 5'd8);

        // Bouncing key 1, toggled every 10 cycles, then held
        wait_frame_start(ok, f);
        check("bn_sync", ok, 1'b1);
        n0 = pc_q.size();
        for (int i = 0; i < 6; i++) begin
            pressed[0] = (i % 2 == 1);
            hold(10);
        end
        check("bn_quiet", pc_q.size() - n0, 0);
        pressed[0] = 1'b1;
        hold(80);
        check("bn_count", pc_q.size() - n0, 1);
        check("bn_value", o_key_value, 5'd1);
        check("bn_latency", pulse_delta(n0, f), 121);
        pressed = '0;
        hold(100);

        // Reset mid-scan while key 6 is held
        pressed[5] = 1'b1;
        hold(100);
        check("mr_pre_value", o_key_value, 5'd6);
        wait_col(5'b11011, ok);
        check("mr_sync_col", ok, 1'b1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("mr_col", o_col, 5'b11110);
        check("mr_value", o_key_value, 5'd0);
        check("mr_valid", o_key_valid, 1'b0);
        hold(2);
        i_rstn = 1'b1;
        f  = cyc;
        n0 = pc_q.size();
        hold(80);
        check("mr_count", pc_q.size() - n0, 1);
        check("mr_value_again", o_key_value, 5'd6);
        check("mr_latency", pulse_delta(n0, f), 61);
        pressed = '0;
        hold(100);

        // Rollover: 13 held, 19 added, 13 released; only 13 reported
        n0 = pc_q.size();
        pressed[12] = 1'b1;
        hold(100);
        check("ro_first_value", o_key_value, 5'd13);
        pressed[18] = 1'b1;
        hold(60);
        pressed[12] = 1'b0;
        hold(120);
        check("ro_count", pc_q.size() - n0, 1);
        check("ro_value", o_key_value, 5'd13);
        pressed = '0;
        hold(100);
        pressed[18] = 1'b1;
        hold(100);
        check("ro_second_count", pc_q.size() - n0, 2);
        check("ro_second_value", o_key_value, 5'd19);
        pressed = '0;
        hold(100);

        // Simultaneous keys 20 and 4: lowest index wins
        wait_frame_start(ok, f);
        check("sim_sync", ok, 1'b1);
        n0 = pc_q.size();
        pressed[19] = 1'b1;
        pressed[3]  = 1'b1;
        hold(100);
        check("sim_count", pc_q.size() - n0, 1);
        check("sim_value", o_key_value, 5'd4);
        pressed = '0;
        hold(100);

        // Long hold of key 3
        wait_col(5'b01111, ok);
        check("rp_sync_col", ok, 1'b1);
        pressed[2] = 1'b1;
        wait_frame_start(ok, f);
        check("rp_sync_frame", ok, 1'b1);
        n0 = pc_q.size();
        hold(300);
        check("rp_first_latency", pulse_delta(n0, f), 61);
        check("rp_value", o_key_value, 5'd3);
`ifdef KEYPAD_REPEAT_EN
        check("rp_count", pc_q.size() - n0, 5);
        if (pc_q.size() >= n0 + 5) begin
            check("rp_gap_delay", pc_q[n0+1] - pc_q[n0], RD * 20);
            check("rp_gap_rate1", pc_q[n0+2] - pc_q[n0+1], RR * 20);
            check("rp_gap_rate3", pc_q[n0+4] - pc_q[n0+3], RR * 20);
            check("rp_last_value", pv_q[n0+4], 5'd3);
        end
`else
        check("rp_count", pc_q.size() - n0, 1);
`endif
        pressed = '0;
        hold(100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner that drives the 4-row × 5-column keypad. It produces the raw key index (1–20) and a one-cycle valid pulse that feed the key-code mapping stage (`i_key_value`/`i_key_valid`). Scanning is column-by-column: one column is driven at a time, rows are synchronised and sampled, presses and releases are debounced over whole frames, and two-key rollover is suppressed by reporting one key per press.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven; must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a press or a release; must be ≥ 1.
- REPEAT_DELAY, 50: frames held before the first auto-repeat. Used only with the repeat feature.
- REPEAT_RATE, 10: frames between subsequent auto-repeats. Used only with the repeat feature.
- i_clk  in  1  system clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_row  in  4  row inputs, active-low (board pull-ups); asynchronous to i_clk.
- o_col  out  5  column drives, active-low, exactly one bit low at any time.
- o_key_value  out  5  accepted key index: row*5 + col + 1 (1..20); 0 after reset.
- o_key_valid  out  1  one-cycle pulse when o_key_value is updated.

## Operation
- **Row input:** i_row passes through a 2-FF synchroniser; only the synchronised value is used.
- **Column scan:**
  - Divider counts 0..SCAN_DIV-1. Column counter counts 0..4 and advances (wrapping 4→0) when the divider reaches SCAN_DIV-1.
  - o_col = ~(1 << col).
- **Row sampling:** rows are sampled on the cycle where divider = SCAN_DIV-1, before the column changes. Row r low ⇒ key (r, col) is pressed.
- **Frame:** one frame is 5 columns = 5*SCAN_DIV cycles. The frame code is the lowest key index seen pressed in the frame, or 0 if none. The frame code is evaluated at the column 4 → 0 wrap.
- **FSM, evaluated once per frame end:**
  - IDLE:
    - frame code ≠ 0 → CAND; candidate = code; match count = 1.
  - CAND:
    - code == candidate → count+1.
    - code ≠ candidate and ≠ 0 → restart with the new candidate, count = 1.
    - code == 0 → IDLE.
    - When count reaches DEBOUNCE_SCANS → HELD, load o_key_value = candidate, pulse o_key_valid.
    - With DEBOUNCE_SCANS = 1, IDLE goes straight to HELD and emits at the first frame end.
  - HELD:
    - Any nonzero code (including a different key) counts as still held, and the release count is cleared.
    - code == 0 → release count+1.
    - Release count reaching DEBOUNCE_SCANS → IDLE.
    - A second key pressed while the first is held is never reported, even after the first is released, until all keys have been released for DEBOUNCE_SCANS frames.
- **Reset mid-operation:** all counters clear, FSM → IDLE, column → 0, outputs return to reset values. A key held through reset is reported again after DEBOUNCE_SCANS frames.

## Timing
- Reset values:
  - o_col = 5'b11110
  - o_key_value = 5'd0
  - o_key_valid = 0
- o_key_value and o_key_valid are registered and update on the same edge, one cycle after the frame-end evaluation. o_key_value holds until the next pulse.
- o_key_valid is high for exactly one cycle per accepted event.
- Press-to-valid latency, with the press stable before a frame start: DEBOUNCE_SCANS frames + 1 cycle, measured from that frame start.
- The minimum spacing between two pulses is 2*DEBOUNCE_SCANS frames: release debounce followed by press debounce.

## Configuration
- **KEYPAD_REPEAT_EN defined:**
  - In HELD, a frame counter runs while the held code is nonzero.
  - After REPEAT_DELAY frames, o_key_valid pulses again with the same o_key_value. Further pulses follow every REPEAT_RATE frames.
  - The counter clears on entry to HELD and on any zero-code frame.
- **KEYPAD_REPEAT_EN undefined:** exactly one pulse per press. The REPEAT_* parameters are ignored and no repeat logic is synthesised.

## Test plan
All scenarios use SCAN_DIV = 4, DEBOUNCE_SCANS = 3, giving a 20-cycle frame. The bench keypad model pulls i_row[r] low when key (r,c) is pressed and o_col[c] is low.

- **Reset:** assert i_rstn = 0 mid-scan → o_col = 11110, o_key_value = 0, o_key_valid = 0 immediately. After release, o_col steps 11110→11101→11011→10111→01111→11110, every 4 cycles.
- **Single press:** press (row 1, col 2) and hold 200 cycles → exactly one o_key_valid pulse with o_key_value = 8, 61 cycles after the first full frame start. Release → no pulse. o_key_value stays 8.
- **Bounce:** toggle key (0,0) every 10 cycles for 60 cycles, then hold → no pulse during bouncing. One pulse with value 1 after 3 clean frames.
- **Rollover:** hold key 13, then add key 19 and release key 13 while 19 stays held → only value 13 is reported. Release all for ≥ 3 frames, press 19 → value 19 reported.
- **Simultaneous press:** press keys 20 and 4 in the same frame → value 4 reported (lowest index), one pulse.
- **Auto-repeat (KEYPAD_REPEAT_EN, REPEAT_DELAY = 5, REPEAT_RATE = 2):** hold key 3 → first pulse, then a pulse 5 frames later, then one every 2 frames, all with value 3. Without the macro, only one pulse.
